// File: rtl/ram_dff_clr_if.sv
// User-side bus of the DFF RAM: access strobe, byte enables, address, data, clear request and busy.
// The master drives accesses; the RAM itself connects through the slave modport.
interface ram_dff_clr_if #(
  parameter int WSIZE = 1,
  parameter int AW    = 3
);
  logic               en;
  logic [WSIZE-1:0]   we;
  logic [AW-1:0]      addr;
  logic [8*WSIZE-1:0] D;
  logic [8*WSIZE-1:0] Q;
  logic               clr;
  logic               busy;

  modport master (output en, we, addr, D, clr, input Q, busy);
  modport slave  (input en, we, addr, D, clr, output Q, busy);
endinterface

// File: rtl/ram_dff_clr.sv
// Single-port DFF RAM with byte enables and a registered, write-through read port.
// A clear engine zero-fills the array after reset or on request before the port is accepted.
module ram_dff_clr #(
  parameter int WORDS = 8,
  parameter int WSIZE = 1
) (
  input  logic         clk,
  input  logic         rst,
  ram_dff_clr_if.slave bus
);
  localparam int AW = $clog2(WORDS);
  localparam int DW = 8 * WSIZE;
  localparam logic [AW-1:0] LAST  = AW'(WORDS - 1);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(WORDS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   ptr, ptr_nx;
  logic [DW-1:0]   mem [WORDS];
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   merged;
  logic [DW-1:0]   wr_word;
  logic [AW-1:0]   wr_addr;
  logic            mem_we;
  logic            in_range;
  logic            access;
  logic [DW-1:0]   q_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      CLEAR: begin
        if (ptr == LAST) begin
          state_nx = READY;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + AW'(1);
        end
      end
      READY: begin
        if (bus.clr) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        ptr_nx   = '0;
      end
    endcase
  end

  // Addresses past WORDS exist only for non-power-of-two depths; they read as zero and never write.
  assign in_range = ({1'b0, bus.addr} < DEPTH);
  assign rd_word  = in_range ? mem[bus.addr] : '0;
  assign access   = (state == READY) && bus.en && !bus.clr;

  for (genvar b = 0; b < WSIZE; b++) begin : g_lane
    assign merged[8*b +: 8] = bus.we[b] ? bus.D[8*b +: 8] : rd_word[8*b +: 8];
  end

  always_comb begin
    mem_we  = 1'b0;
    wr_addr = bus.addr;
    wr_word = merged;
    if (state == CLEAR) begin
      mem_we  = 1'b1;
      wr_addr = ptr;
      wr_word = '0;
    end else if (access && in_range && (|bus.we)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (state == CLEAR || bus.clr) begin
      q_r <= '0;
    end else if (bus.en) begin
      q_r <= in_range ? merged : '0;
    end
  end

  assign bus.Q    = q_r;
  assign bus.busy = (state == CLEAR);
endmodule

// File: tb/tb_ram_dff_clr.sv
// Directed bench for ram_dff_clr: three instances (8x8, 8x32, 6x8) sharing clock and reset.
// Expected values are hand-computed constants.
module tb_ram_dff_clr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ram_dff_clr_if #(.WSIZE(1), .AW(3)) b8 ();
  ram_dff_clr_if #(.WSIZE(4), .AW(3)) b4 ();
  ram_dff_clr_if #(.WSIZE(1), .AW(3)) b6 ();

  ram_dff_clr #(.WORDS(8), .WSIZE(1)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  ram_dff_clr #(.WORDS(8), .WSIZE(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  ram_dff_clr #(.WORDS(6), .WSIZE(1)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b8.en = 0; b8.we = '0; b8.addr = '0; b8.D = '0; b8.clr = 0;
    b4.en = 0; b4.we = '0; b4.addr = '0; b4.D = '0; b4.clr = 0;
    b6.en = 0; b6.we = '0; b6.addr = '0; b6.D = '0; b6.clr = 0;

    #12;
    check("rst_q8", 32'(b8.Q), 32'h0);
    check("rst_busy8", 32'(b8.busy), 32'h1);
    check("rst_q4", b4.Q, 32'h0);
    check("rst_busy4", 32'(b4.busy), 32'h1);
    check("rst_q6", 32'(b6.Q), 32'h0);
    check("rst_busy6", 32'(b6.busy), 32'h1);

    @(negedge clk); rst = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("clear_busy8", 32'(b8.busy), 32'(i < 8));
      check("clear_busy4", 32'(b4.busy), 32'(i < 8));
      check("clear_busy6", 32'(b6.busy), 32'(i < 6));
    end

    for (int a = 0; a < 8; a++) begin
      b8.en = 1; b8.we = 1'b0; b8.addr = 3'(a);
      tick();
      check("init_read8", 32'(b8.Q), 32'h0);
    end

    b8.en = 1; b8.we = 1'b1; b8.addr = 3'd3; b8.D = 8'hA5;
    tick();
    check("wr_through8", 32'(b8.Q), 32'hA5);
    b8.en = 0; b8.we = 1'b0;
    tick();
    check("idle_hold8", 32'(b8.Q), 32'hA5);
    b8.en = 1; b8.addr = 3'd0;
    tick();
    check("read8_a0", 32'(b8.Q), 32'h0);
    b8.addr = 3'd3;
    tick();
    check("read8_a3", 32'(b8.Q), 32'hA5);
    b8.en = 0;

    b4.en = 1; b4.we = 4'b1111; b4.addr = 3'd5; b4.D = 32'h11223344;
    tick();
    check("wr4_full", b4.Q, 32'h11223344);
    b4.we = 4'b0101; b4.D = 32'hFFFFFFFF;
    tick();
    check("wr4_partial", b4.Q, 32'h11FF33FF);
    b4.we = 4'b0000;
    tick();
    check("read4_a5", b4.Q, 32'h11FF33FF);
    b4.addr = 3'd4;
    tick();
    check("read4_a4", b4.Q, 32'h0);
    b4.en = 0;

    b6.en = 1; b6.we = 1'b1; b6.addr = 3'd1; b6.D = 8'h55;
    tick();
    check("wr6_a1", 32'(b6.Q), 32'h55);
    b6.addr = 3'd7; b6.D = 8'h7E;
    tick();
    check("wr6_oob", 32'(b6.Q), 32'h0);
    b6.we = 1'b0;
    for (int a = 0; a < 6; a++) begin
      b6.addr = 3'(a);
      tick();
      check("read6_alias", 32'(b6.Q), (a == 1) ? 32'h55 : 32'h0);
    end
    b6.addr = 3'd1;
    tick();
    check("read6_a1", 32'(b6.Q), 32'h55);
    b6.addr = 3'd6;
    tick();
    check("read6_oob", 32'(b6.Q), 32'h0);
    b6.en = 0;

    b8.en = 1; b8.we = 1'b1; b8.addr = 3'd2; b8.D = 8'h3C;
    tick();
    check("wr8_a2", 32'(b8.Q), 32'h3C);
    b8.D = 8'h99; b8.clr = 1;
    tick();
    check("clr_busy", 32'(b8.busy), 32'h1);
    check("clr_q", 32'(b8.Q), 32'h0);
    b8.addr = 3'd3; b8.D = 8'h77;
    for (int i = 1; i <= 8; i++) begin
      b8.clr = (i == 3);
      tick();
      check("clr_sweep_busy", 32'(b8.busy), 32'(i < 8));
      check("clr_sweep_q", 32'(b8.Q), 32'h0);
    end
    b8.clr = 0; b8.en = 1; b8.we = 1'b0; b8.addr = 3'd2;
    tick();
    check("clr_read_a2", 32'(b8.Q), 32'h0);
    b8.addr = 3'd3;
    tick();
    check("clr_read_a3", 32'(b8.Q), 32'h0);

    b8.we = 1'b1; b8.addr = 3'd1; b8.D = 8'h5A;
    tick();
    check("wr8_a1", 32'(b8.Q), 32'h5A);
    b8.en = 0; b8.we = 1'b0;
    b6.clr = 1;
    tick();
    b6.clr = 0;
    repeat (4) tick();
    check("mid_busy6", 32'(b6.busy), 32'h1);
    check("mid_hold8", 32'(b8.Q), 32'h5A);
    rst = 1;
    #1;
    check("async_q8", 32'(b8.Q), 32'h0);
    check("async_busy8", 32'(b8.busy), 32'h1);
    check("async_busy4", 32'(b4.busy), 32'h1);
    @(posedge clk);
    @(negedge clk); rst = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("rerst_busy8", 32'(b8.busy), 32'(i < 8));
      check("rerst_busy4", 32'(b4.busy), 32'(i < 8));
      check("rerst_busy6", 32'(b6.busy), 32'(i < 6));
    end
    for (int a = 0; a < 8; a++) begin
      b8.en = 1; b8.addr = 3'(a);
      b4.en = 1; b4.addr = 3'(a);
      tick();
      check("rerst_read8", 32'(b8.Q), 32'h0);
      check("rerst_read4", b4.Q, 32'h0);
    end
    b8.en = 0; b4.en = 0;
    for (int a = 0; a < 6; a++) begin
      b6.en = 1; b6.addr = 3'(a);
      tick();
      check("rerst_read6", 32'(b6.Q), 32'h0);
    end
    b6.en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
